// File: rtl/accum_engine.sv
// ============================================================================
// Module   : accum_engine
// Purpose  : Round-based step accumulator answering the round controller,
//            saturating and locking at LIMIT until the enable is dropped.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module accum_engine #(
  parameter int STEPS    = 4,
  parameter int LIMIT    = 100,
  parameter int MAX_STEP = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step_en,
  input  logic       judge,
  input  logic       control_set,
  input  logic [5:0] input_num,
  output logic [5:0] now_num,
  output logic [9:0] sum_num,
  output logic [5:0] flag,
  output logic       busy,
  output logic       full,
  output logic       err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_FULL = 2'd3;

  localparam logic [9:0] c_limit    = 10'(LIMIT);
  localparam logic [5:0] c_steps    = 6'(STEPS);
  localparam logic [5:0] c_max_step = 6'(MAX_STEP);

  logic [1:0] r_state;
  logic [5:0] r_now;
  logic [9:0] r_sum;
  logic [5:0] r_flag;
  logic       r_err;

  logic [9:0] w_sum_next;
  logic [5:0] w_flag_inc;
  logic       w_step_legal;

  assign w_sum_next   = r_sum + {4'b0000, r_now};
  assign w_flag_inc   = r_flag + 6'd1;
  assign w_step_legal = (input_num != 6'd0) && (input_num <= c_max_step);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_now   <= 6'd0;
      r_sum   <= 10'd0;
      r_flag  <= 6'd0;
      r_err   <= 1'b0;
    end else if (!control_set) begin
      r_state <= S_IDLE;
      r_now   <= 6'd0;
      r_sum   <= 10'd0;
      r_flag  <= 6'd0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // A saturated total must never be re-armed; park it in FULL.
          if (r_sum == c_limit) begin
            r_state <= S_FULL;
          end else if (judge) begin
            if (w_step_legal) begin
              r_now   <= input_num;
              r_flag  <= 6'd0;
              r_state <= S_RUN;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_RUN: begin
          // Abort outranks a coincident step strobe.
          if (!judge) begin
            r_state <= S_IDLE;
          end else if (step_en) begin
            r_flag <= w_flag_inc;
            if (w_sum_next >= c_limit) begin
              r_sum   <= c_limit;
              r_state <= S_FULL;
            end else begin
              r_sum <= w_sum_next;
              if (w_flag_inc == c_steps) begin
                r_state <= S_DONE;
              end
            end
          end
        end
        S_DONE: begin
          if (!judge) begin
            r_flag  <= 6'd0;
            r_state <= S_IDLE;
          end
        end
        S_FULL: begin
          r_state <= S_FULL;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign now_num = r_now;
  assign sum_num = r_sum;
  assign flag    = r_flag;
  assign err     = r_err;
  assign busy    = (r_state == S_RUN);
  assign full    = (r_state == S_FULL);

endmodule

`default_nettype wire

// File: tb/tb_accum_engine.sv
// ============================================================================
// Module   : tb_accum_engine
// Purpose  : Self-checking bench for accum_engine against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_accum_engine;

  localparam int STEPS    = 4;
  localparam int LIMIT    = 100;
  localparam int MAX_STEP = 30;

  logic       clk = 1'b0;
  logic       rst;
  logic       step_en;
  logic       judge;
  logic       control_set;
  logic [5:0] input_num;
  logic [5:0] now_num;
  logic [9:0] sum_num;
  logic [5:0] flag;
  logic       busy;
  logic       full;
  logic       err;

  int tests = 0;
  int fails = 0;

  // Reference model: round activity described by three booleans
  bit m_running, m_finished, m_locked;
  int m_now, m_sum, m_flag;
  bit m_err;

  accum_engine #(.STEPS(STEPS), .LIMIT(LIMIT), .MAX_STEP(MAX_STEP)) dut (
    .clk        (clk),
    .rst        (rst),
    .step_en    (step_en),
    .judge      (judge),
    .control_set(control_set),
    .input_num  (input_num),
    .now_num    (now_num),
    .sum_num    (sum_num),
    .flag       (flag),
    .busy       (busy),
    .full       (full),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_running = 0; m_finished = 0; m_locked = 0;
    m_now = 0; m_sum = 0; m_flag = 0; m_err = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    int total;
    if (!control_set) begin
      model_clear();
    end else if (m_locked) begin
      m_err = 0;
    end else if (m_running) begin
      m_err = 0;
      if (!judge) begin
        m_running = 0;
      end else if (step_en) begin
        total  = m_sum + m_now;
        m_flag = m_flag + 1;
        if (total >= LIMIT) begin
          m_sum = LIMIT; m_running = 0; m_locked = 1;
        end else begin
          m_sum = total;
          if (m_flag == STEPS) begin
            m_running = 0; m_finished = 1;
          end
        end
      end
    end else if (m_finished) begin
      m_err = 0;
      if (!judge) begin
        m_finished = 0; m_flag = 0;
      end
    end else begin
      m_err = 0;
      if (m_sum == LIMIT) m_locked = 1;
      else if (judge) begin
        if (input_num >= 1 && input_num <= MAX_STEP) begin
          m_now = int'(input_num); m_flag = 0; m_running = 1;
        end else begin
          m_err = 1;
        end
      end
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".now"},  int'(now_num), m_now);
    chk({tag, ".sum"},  int'(sum_num), m_sum);
    chk({tag, ".flag"}, int'(flag),    m_flag);
    chk({tag, ".busy"}, int'(busy),    int'(m_running));
    chk({tag, ".full"}, int'(full),    int'(m_locked));
    chk({tag, ".err"},  int'(err),     int'(m_err));
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  initial begin
    rst = 1'b1; step_en = 1'b0; judge = 1'b0; control_set = 1'b0; input_num = 6'd0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Four-step round of 7s, then controller drops judge
    control_set = 1'b1; input_num = 6'd7; judge = 1'b1;
    tick("t1_start");
    chk("t1_busy", int'(busy), 1);
    step_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick("t1_step");
      chk("t1_sum", int'(sum_num), 7 * i);
      chk("t1_flag", int'(flag), i);
    end
    step_en = 1'b0;
    chk("t1_done_busy", int'(busy), 0);
    judge = 1'b0;
    tick("t1_release");
    chk("t1_flag_clr", int'(flag), 0);
    chk("t1_sum_keep", int'(sum_num), 28);

    // Illegal step values pulse err every cycle
    judge = 1'b1; input_num = 6'd0;
    tick("t2_zero");
    chk("t2_err0", int'(err), 1);
    input_num = 6'd31;
    tick("t2_big");
    chk("t2_err31", int'(err), 1);
    chk("t2_now", int'(now_num), 7);
    judge = 1'b0;
    tick("t2_idle");
    chk("t2_err_clr", int'(err), 0);

    // Saturation at LIMIT and lock
    control_set = 1'b0;
    tick("t3_clear");
    control_set = 1'b1; input_num = 6'd30; judge = 1'b1;
    tick("t3_start");
    step_en = 1'b1;
    for (int i = 1; i <= 4; i++) tick("t3_step");
    chk("t3_sum", int'(sum_num), LIMIT);
    chk("t3_full", int'(full), 1);
    chk("t3_flag", int'(flag), 4);
    judge = 1'b0;
    tick("t3_lock_a");
    judge = 1'b1;
    tick("t3_lock_b");
    chk("t3_sum_locked", int'(sum_num), LIMIT);
    step_en = 1'b0;

    // Soft clear mid-round, then restart
    control_set = 1'b0;
    tick("t4_clear");
    control_set = 1'b1; input_num = 6'd5;
    tick("t4_start");
    step_en = 1'b1;
    tick("t4_s1");
    tick("t4_s2");
    chk("t4_sum10", int'(sum_num), 10);
    step_en = 1'b0; control_set = 1'b0;
    tick("t4_softclr");
    chk("t4_sum0", int'(sum_num), 0);
    chk("t4_busy0", int'(busy), 0);
    control_set = 1'b1; input_num = 6'd3;
    tick("t4_restart");
    step_en = 1'b1;
    tick("t4_add");
    chk("t4_sum3", int'(sum_num), 3);
    step_en = 1'b0;

    // Abort coinciding with a step strobe
    control_set = 1'b0;
    tick("t5_clear");
    control_set = 1'b1; input_num = 6'd6;
    tick("t5_start");
    step_en = 1'b1;
    tick("t5_s1");
    judge = 1'b0;
    tick("t5_abort");
    chk("t5_sum6", int'(sum_num), 6);
    chk("t5_flag1", int'(flag), 1);
    chk("t5_busy0", int'(busy), 0);
    step_en = 1'b0;

    // Asynchronous reset between edges
    judge = 1'b1; input_num = 6'd4;
    tick("t6_start");
    step_en = 1'b1;
    tick("t6_s1");
    step_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_clear();
    compare_all("t6_async");
    #2 rst = 1'b0;
    judge = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      control_set = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 7) == 0) judge = ~judge;
      step_en   = 1'($urandom_range(0, 1));
      input_num = 6'($urandom_range(0, 40));
      tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/accum_engine.md
Name: accum_engine

Overview:
- Responder side of the round-control handshake: accepts a step value plus a run request from the round controller.
- Adds the step value into a running total STEPS times per round, paced by a step strobe.
- Reports round progress (flag), the latched step (now_num) and the running total (sum_num) back to the controller and the 7-segment display path.
- Saturates and locks at LIMIT until the controller's enable is dropped.

Parameters:
- STEPS, 4: additions per round; flag counts 0..STEPS.
- LIMIT, 100: total ceiling; sum_num never exceeds it.
- MAX_STEP, 30: largest legal step value.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- step_en  in  1  single-cycle pacing strobe; one addition per strobe while running
- judge  in  1  run request from the controller, level
- control_set  in  1  enable; low = soft clear
- input_num  in  6  step value, sampled at round start
- now_num  out  6  latched step of the current/last round
- sum_num  out  10  running total, 0..LIMIT
- flag  out  6  additions completed in the current round
- busy  out  1  high in RUN
- full  out  1  high in FULL
- err  out  1  high one cycle when a start request carries an illegal step

Behaviour:
- Design has one clock and an asynchronous, active-high reset.
- Reset: state=IDLE; now_num=0, sum_num=0, flag=0, busy=0, full=0, err=0.
- Priority, highest first: rst; control_set=0; state logic.
- control_set=0, any state: next edge forces IDLE and clears now_num, sum_num, flag and err. Holds while low.
- IDLE:
  - judge=1 and control_set=1 and 1<=input_num<=MAX_STEP: latch now_num<=input_num, flag<=0, go to RUN.
  - judge=1 with input_num=0 or >MAX_STEP: err pulses for 1 cycle, stay IDLE, outputs otherwise unchanged. Re-pulses every cycle the condition holds.
  - sum_num==LIMIT on entry to IDLE: go to FULL instead.
- RUN (busy=1), on each step_en:
  - s = sum_num + now_num, computed 10 bits wide.
  - If s >= LIMIT: sum_num<=LIMIT, flag<=flag+1, go to FULL.
  - Else: sum_num<=s, flag<=flag+1. If flag+1==STEPS, go to DONE.
  - No step_en: hold all outputs.
  - judge dropped mid-round: abort to IDLE; flag and sum_num keep their values.
- DONE:
  - flag holds STEPS, so the controller can observe flag==STEPS.
  - When judge=0: go to IDLE and clear flag to 0 on that edge.
  - While judge stays 1: remain in DONE; no new round starts without a judge low→high cycle.
- FULL:
  - full=1, busy=0, sum_num=LIMIT, flag frozen. judge and step_en are ignored.
  - Exit only through control_set=0 or rst.
- Latency:
  - Round start: 1 cycle from judge sampled high to busy=1.
  - Each addition: visible in sum_num 1 cycle after step_en.
  - step_en on the start edge is ignored.
- A new input_num during RUN or DONE has no effect; it is sampled only in IDLE.
- Simultaneous step_en and judge fall in RUN: the abort wins and no addition is made.

Test Plan:
- rst, control_set=1, input_num=7, judge=1, then 4 step_en pulses → sum_num 7,14,21,28; flag 1..4; state DONE, busy=0. Drop judge → flag=0, sum_num=28.
- input_num=30, run 4 rounds of 4 steps → sum_num reaches 90 after the 3rd add of round 1 and saturates at 100 on the 4th add. full=1, flag=4. Further judge and step_en produce no change.
- input_num=0 then input_num=31 with judge=1 → err pulses, state stays IDLE, sum_num and now_num unchanged.
- Mid-RUN (flag=2, sum_num=10 at step 5): control_set=0 for 1 cycle → all outputs 0, IDLE. Re-enable with input_num=3 → first add gives sum_num=3.
- Assert rst asynchronously between clock edges during RUN → outputs 0 immediately, before the next clk edge.
- Pulse step_en on the same edge judge falls in RUN (flag=1, sum_num=6) → abort to IDLE, sum_num stays 6, flag stays 1.
